lookahead_routing_mc: RTL and testbench
=======================================

Name: lookahead_routing_mc

Overview:
Parametrised multicast lookahead routing stage for the 2D-mesh NoC router.
- Takes a header's destination list, valid mask and the one-hot direction of the current hop.
- Computes, for the next-hop router, the one-hot port each destination leaves on, plus per-port destination masks so that router can replicate or split the flit.
- Registered, with a valid/ready handshake, edge/self/one-hot error detection and sticky error status.
- Sits between the input-unit header decode and the switch allocator.

Parameters:
DEST_SIZE, 6, max destinations per header (1..16).
MESH_X, 8, mesh columns; valid x is 0..MESH_X-1.
MESH_Y, 8, mesh rows; valid y is 0..MESH_Y-1.
X_FIRST, 1, 1 = resolve X (west/east) before Y; 0 = Y before X.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
position  in  noc::xy_t  static router coordinates, sampled every cycle.
in_valid  in  1  header request valid.
in_ready  out  1  stage can accept a request.
in_destination  in  noc::xy_t[DEST_SIZE]  destination coordinates.
in_val  in  DEST_SIZE  destination valid mask.
in_current_routing  in  noc::direction_t  one-hot direction for the current hop.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_next_routing  out  noc::direction_t  OR of per-destination next-hop directions.
out_port_mask  out  [5][DEST_SIZE]  per port (noc port index), destinations routed to it.
out_err  out  3  per-request flags: {edge, self, onehot}.
err_status  out  3  sticky OR of out_err over accepted results.
clear_err  in  1  synchronous clear of err_status.

Behaviour:
Reset values:
- out_valid=0, in_ready=0, out_next_routing=0, out_port_mask=0, out_err=0, err_status=0.
- position_q=0, pos_ok=0.

Position capture:
- position_q<=position every cycle.
- pos_ok is set on the first clock after reset deassertion.
- in_ready = pos_ok && (!out_valid || out_ready), so there is one dead cycle after reset.

Next-hop position n (from position_q and in_current_routing):
- North: y-1. South: y+1. West: x-1. East: x+1.
- Arithmetic is in xy_t coordinate width.

Per-destination route, valid i only. With X_FIRST=1:
- d.x<n.x: West.
- d.x>n.x: East.
- d.y<n.y: North.
- d.y>n.y: South.
- Otherwise: Local.
With X_FIRST=0, the X and Y comparisons swap order.

Error handling:
- onehot error: in_current_routing is not exactly one-hot while any in_val bit is set.
  - All routes are forced to 0.
- go_local: the current hop ejects, so all routes are 0 and no error is raised.
- edge error: the hop leaves the mesh (West at x=0, East at x=MESH_X-1, North at y=0, South at y=MESH_Y-1).
  - All routes are forced to 0; no wrap is ever produced.
- self error: a valid destination equals position_q while current_routing is not local.
  - That destination's route is 0 (bit excluded); other destinations route normally.
- in_val=0 produces all-zero outputs and no error.

Outputs:
- out_port_mask[p][i]=1 iff destination i routes to port p.
- out_next_routing = OR over i of per-destination routes.

Pipeline:
- One register stage, latency 1: fire = in_valid && in_ready loads all out_* on the next edge.
- out_valid drops when out_ready && !fire.
- Outputs hold stable while out_valid && !out_ready.
- Back-to-back fires sustain 1 result/cycle.

err_status:
- err_status |= out_err when out_valid && out_ready.
- clear_err wins over a simultaneous set in the same cycle.

Reset asserted mid-transfer drops any pending result; no output glitch beyond the async clear.

Decomposition:
noc package additions:
- kNumPorts=5.
- port_mask_t.
- Constant for routing-order selection.
- Function xy_route(next, dest, x_first) returning direction_t.

Sub-module: lookahead_route_calc, purely combinational. It holds:
- Next-position select.
- Edge/one-hot checks.
- Per-destination route and mask generation.
Top module holds the position register, handshake, output register and sticky status.

Test Plan:
1. Reset, position=(3,3) -> in_ready=0 for 1 cycle, then 1; all outputs 0.
2. current=East, dest0=(6,3), dest1=(4,1), val=2'b11 -> next hop (4,3).
   - dest0 East, dest1 North; out_next_routing=goEast|goNorth.
   - out_port_mask[East]=000001, out_port_mask[North]=000010; latency 1.
3. position=(0,2), current=West, val=1 -> out_err=edge, next_routing=0, err_status[edge]=1 after accept.
   - clear_err then clears it; simultaneous set and clear leaves it 0.
4. current=5'b00110, val=1 -> onehot error, masks 0; val=0 with the same routing -> no error.
5. Backpressure: out_ready=0 for 3 cycles after fire -> outputs stable, in_ready=0.
   - Then out_ready=1 with a new in_valid -> accepted same cycle, 1 result/cycle for 4 back-to-back headers.
6. X_FIRST=0 build, current=North from (2,5), dest=(4,1) -> next hop (2,4), route North (Y first), not East.

Source files
------------

// File: rtl/noc.sv
// -----------------------------------------------------------------------------
// noc: shared types and helpers for the 2D-mesh NoC router.
//
//   xy_t         packed {x, y} router coordinate
//   direction_t  one-hot output direction, bit index = noc port index
//   port_mask_t  per-port destination mask at the widest header size
//   xy_route()   dimension-ordered route from the next hop to one destination
// -----------------------------------------------------------------------------
package noc;

    localparam int kCoordW   = 4;
    localparam int kNumPorts = 5;
    localparam int kMaxDest  = 16;

    // Port indices; direction_t bit p selects port p.
    localparam int kPortLocal = 0;
    localparam int kPortNorth = 1;
    localparam int kPortEast  = 2;
    localparam int kPortSouth = 3;
    localparam int kPortWest  = 4;

    // Bit positions inside the {edge, self, onehot} error vector.
    localparam int kErrOnehot = 0;
    localparam int kErrSelf   = 1;
    localparam int kErrEdge   = 2;

    // Routing-order selection for X_FIRST.
    localparam bit kXFirst = 1'b1;
    localparam bit kYFirst = 1'b0;

    typedef struct packed {
        logic [kCoordW-1:0] x;
        logic [kCoordW-1:0] y;
    } xy_t;

    typedef logic [kNumPorts-1:0] direction_t;

    localparam direction_t go_local = 5'b00001;
    localparam direction_t go_north = 5'b00010;
    localparam direction_t go_east  = 5'b00100;
    localparam direction_t go_south = 5'b01000;
    localparam direction_t go_west  = 5'b10000;

    typedef logic [kMaxDest-1:0]       dest_mask_t;
    typedef dest_mask_t [kNumPorts-1:0] port_mask_t;

    // Dimension-ordered route: the first dimension that still differs wins,
    // and a destination matching the next hop in both dimensions ejects.
    function automatic direction_t xy_route(input xy_t next_pos, input xy_t dest,
                                            input bit x_first);
        direction_t x_dir;
        direction_t y_dir;
        direction_t result;
        x_dir = '0;
        y_dir = '0;
        if (dest.x < next_pos.x)      x_dir = go_west;
        else if (dest.x > next_pos.x) x_dir = go_east;
        if (dest.y < next_pos.y)      y_dir = go_north;
        else if (dest.y > next_pos.y) y_dir = go_south;
        if (x_first) result = (x_dir != '0) ? x_dir : y_dir;
        else         result = (y_dir != '0) ? y_dir : x_dir;
        if (result == '0) result = go_local;
        return result;
    endfunction

endpackage

// File: rtl/lookahead_route_calc.sv
// -----------------------------------------------------------------------------
// lookahead_route_calc: combinational core of the lookahead routing stage.
//
// Given the current router position and the one-hot direction the header
// takes out of this router, it derives the next-hop coordinate and, for every
// valid destination, the port that destination leaves the next-hop router on.
//
// Ports
//   position        current router coordinate (registered by the parent)
//   destination     per-destination coordinates
//   val             destination valid mask
//   current_routing one-hot direction of the current hop
//   next_routing    OR of all per-destination next-hop directions
//   port_mask       [port][dest] = destination routed to that port
//   err             {edge, self, onehot}
// -----------------------------------------------------------------------------
module lookahead_route_calc
    import noc::*;
#(
    parameter int DEST_SIZE = 6,
    parameter int MESH_X    = 8,
    parameter int MESH_Y    = 8,
    parameter bit X_FIRST   = kXFirst
) (
    input  xy_t                                 position,
    input  xy_t                                 destination [DEST_SIZE],
    input  logic [DEST_SIZE-1:0]                val,
    input  direction_t                          current_routing,
    output direction_t                          next_routing,
    output logic [kNumPorts-1:0][DEST_SIZE-1:0] port_mask,
    output logic [2:0]                          err
);

    localparam logic [kCoordW-1:0] kOne  = kCoordW'(1);
    localparam logic [kCoordW-1:0] kMaxX = kCoordW'(MESH_X - 1);
    localparam logic [kCoordW-1:0] kMaxY = kCoordW'(MESH_Y - 1);

    xy_t                  next_pos;
    logic                 hop_edge;
    logic                 any_val;
    logic                 onehot_ok;
    logic                 hop_local;
    logic                 route_en;
    logic [DEST_SIZE-1:0] is_self;
    direction_t           route [DEST_SIZE];

    assign any_val   = |val;
    assign onehot_ok = $onehot(current_routing);
    assign hop_local = (current_routing == go_local);
    // Leaving the mesh or ejecting here means the next router never sees it.
    assign route_en  = onehot_ok && !hop_local && !hop_edge;

    // Next-hop coordinate. The edge test is done on the current position so a
    // wrapped coordinate is never used to route.
    always_comb begin : next_hop
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        next_pos = position;
        hop_edge = 1'b0;
        case (current_routing)
            go_north: begin
                next_pos.y = position.y - kOne;
                hop_edge   = (position.y == '0);
            end
            go_south: begin
                next_pos.y = position.y + kOne;
                hop_edge   = (position.y == kMaxY);
            end
            go_west: begin
                next_pos.x = position.x - kOne;
                hop_edge   = (position.x == '0);
            end
            go_east: begin
                next_pos.x = position.x + kOne;
                hop_edge   = (position.x == kMaxX);
            end
            default: ;
        endcase
    end

    // A destination equal to this router should already have ejected here,
    // so it is dropped from the lookahead result instead of bouncing back.
    always_comb begin : per_dest
        is_self = '0;
        for (int i = 0; i < DEST_SIZE; i++) begin
            is_self[i] = val[i] && (destination[i] == position);
            route[i]   = '0;
            if (val[i] && route_en && !is_self[i])
                route[i] = xy_route(next_pos, destination[i], X_FIRST);
        end
    end

    always_comb begin : collect
        next_routing = '0;
        port_mask    = '0;
        for (int i = 0; i < DEST_SIZE; i++) begin
            next_routing = next_routing | route[i];
            for (int p = 0; p < kNumPorts; p++)
                port_mask[p][i] = route[i][p];
        end
    end

    assign err[kErrOnehot] = any_val && !onehot_ok;
    assign err[kErrEdge]   = any_val && onehot_ok && hop_edge;
    assign err[kErrSelf]   = onehot_ok && !hop_local && (|is_self);

endmodule

// File: rtl/lookahead_routing_mc.sv
// -----------------------------------------------------------------------------
// lookahead_routing_mc: registered multicast lookahead routing stage.
//
// Sits between input-unit header decode and the switch allocator. A header
// accepted on in_valid/in_ready produces, one cycle later, the next-hop
// directions and per-port destination masks for the downstream router.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   position            static router coordinate, registered every cycle
//   in_valid/in_ready   request handshake
//   in_destination      destination coordinates
//   in_val              destination valid mask
//   in_current_routing  one-hot direction of the current hop
//   out_valid/out_ready result handshake
//   out_next_routing    OR of per-destination next-hop directions
//   out_port_mask       [port][dest] destinations routed to each port
//   out_err             {edge, self, onehot} for this result
//   err_status          sticky OR of out_err over accepted results
//   clear_err           synchronous clear of err_status (wins over a set)
// -----------------------------------------------------------------------------
module lookahead_routing_mc
    import noc::*;
#(
    parameter int DEST_SIZE = 6,
    parameter int MESH_X    = 8,
    parameter int MESH_Y    = 8,
    parameter bit X_FIRST   = kXFirst
) (
    input  logic                                clk,
    input  logic                                rst,
    input  xy_t                                 position,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  xy_t                                 in_destination [DEST_SIZE],
    input  logic [DEST_SIZE-1:0]                in_val,
    input  direction_t                          in_current_routing,
    output logic                                out_valid,
    input  logic                                out_ready,
    output direction_t                          out_next_routing,
    output logic [kNumPorts-1:0][DEST_SIZE-1:0] out_port_mask,
    output logic [2:0]                          out_err,
    output logic [2:0]                          err_status,
    input  logic                                clear_err
);

    xy_t                                 position_q;
    logic                                pos_ok;
    logic                                fire;
    direction_t                          calc_routing;
    logic [kNumPorts-1:0][DEST_SIZE-1:0] calc_mask;
    logic [2:0]                          calc_err;

    // The position strap is only trusted once it has been registered, which
    // gives one dead cycle after reset before the first request is taken.
    always_ff @(posedge clk or posedge rst) begin : pos_reg
        // NOTE: flops use non-blocking assignments so every register samples
        // pre-edge values regardless of block ordering.
        if (rst) begin
            position_q <= '0;
            pos_ok     <= 1'b0;
        end else begin
            position_q <= position;
            pos_ok     <= 1'b1;
        end
    end

    lookahead_route_calc #(
        .DEST_SIZE (DEST_SIZE),
        .MESH_X    (MESH_X),
        .MESH_Y    (MESH_Y),
        .X_FIRST   (X_FIRST)
    ) u_calc (
        .position        (position_q),
        .destination     (in_destination),
        .val             (in_val),
        .current_routing (in_current_routing),
        .next_routing    (calc_routing),
        .port_mask       (calc_mask),
        .err             (calc_err)
    );

    // Single-entry pipeline: a new header is taken whenever the held result
    // is absent or leaving this cycle, which sustains one result per cycle.
    assign in_ready = pos_ok && (!out_valid || out_ready);
    assign fire     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin : out_reg
        if (rst) begin
            out_valid        <= 1'b0;
            out_next_routing <= '0;
            out_port_mask    <= '0;
            out_err          <= '0;
        end else if (fire) begin
            out_valid        <= 1'b1;
            out_next_routing <= calc_routing;
            out_port_mask    <= calc_mask;
            out_err          <= calc_err;
        end else if (out_ready) begin
            out_valid        <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : err_reg
        if (rst)
            err_status <= '0;
        else if (clear_err)
            err_status <= '0;
        else if (out_valid && out_ready)
            err_status <= err_status | out_err;
    end

endmodule

// File: tb/tb_lookahead_routing_mc.sv
// -----------------------------------------------------------------------------
// tb_lookahead_routing_mc: scoreboard bench for lookahead_routing_mc.
// Two instances share all inputs: dut_a resolves X first, dut_b Y first.
// Inputs change 1 time unit after the rising edge; the monitor samples on the
// falling edge, pushes model results on fire and compares on output.
// -----------------------------------------------------------------------------
module tb_lookahead_routing_mc;
    import noc::*;

    localparam int DS     = 6;
    localparam int MESH_X = 8;
    localparam int MESH_Y = 8;

    typedef struct packed {
        direction_t                   nr;
        logic [kNumPorts-1:0][DS-1:0] mask;
        logic [2:0]                   err;
    } exp_t;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    xy_t                          position;
    logic                         in_valid;
    xy_t                          in_destination [DS];
    logic [DS-1:0]                in_val;
    direction_t                   in_current_routing;
    logic                         out_ready;
    logic                         clear_err;

    logic                         in_ready, in_ready_b;
    logic                         out_valid, out_valid_b;
    direction_t                   out_next_routing, out_next_routing_b;
    logic [kNumPorts-1:0][DS-1:0] out_port_mask, out_port_mask_b;
    logic [2:0]                   out_err, out_err_b;
    logic [2:0]                   err_status, err_status_b;

    int   total_cnt = 0;
    int   bad_cnt   = 0;
    exp_t q_a [$];
    exp_t q_b [$];
    logic m_valid   = 1'b0;
    logic m_pos_ok  = 1'b0;
    xy_t  pos_q_m   = '0;
    logic [2:0] exp_status = '0;

    always #5 clk = ~clk;

    lookahead_routing_mc #(.DEST_SIZE(DS), .MESH_X(MESH_X), .MESH_Y(MESH_Y), .X_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .position(position), .in_valid(in_valid), .in_ready(in_ready),
        .in_destination(in_destination), .in_val(in_val), .in_current_routing(in_current_routing),
        .out_valid(out_valid), .out_ready(out_ready), .out_next_routing(out_next_routing),
        .out_port_mask(out_port_mask), .out_err(out_err), .err_status(err_status),
        .clear_err(clear_err));

    lookahead_routing_mc #(.DEST_SIZE(DS), .MESH_X(MESH_X), .MESH_Y(MESH_Y), .X_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .position(position), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_destination(in_destination), .in_val(in_val), .in_current_routing(in_current_routing),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_next_routing(out_next_routing_b),
        .out_port_mask(out_port_mask_b), .out_err(out_err_b), .err_status(err_status_b),
        .clear_err(clear_err));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic xy_t xy(input int x, input int y);
        xy_t r;
        r.x = kCoordW'(x);
        r.y = kCoordW'(y);
        return r;
    endfunction

    // Reference model written with signed integer coordinates.
    function automatic exp_t model(input xy_t pos, input direction_t cur, input xy_t d [DS],
                                   input logic [DS-1:0] v, input bit x_first);
        exp_t e;
        int   ones, nx, ny, dx, dy, port;
        bit   self_i;
        e = '0;
        if (v == '0) return e;
        ones = 0;
        for (int b = 0; b < kNumPorts; b++) ones += int'(cur[b]);
        if (ones != 1) begin
            e.err[kErrOnehot] = 1'b1;
            return e;
        end
        if (cur[kPortLocal]) return e;
        nx = int'(pos.x);
        ny = int'(pos.y);
        if (cur[kPortNorth]) ny--;
        if (cur[kPortSouth]) ny++;
        if (cur[kPortWest])  nx--;
        if (cur[kPortEast])  nx++;
        for (int i = 0; i < DS; i++)
            if (v[i] && d[i].x == pos.x && d[i].y == pos.y) e.err[kErrSelf] = 1'b1;
        if (nx < 0 || ny < 0 || nx >= MESH_X || ny >= MESH_Y) begin
            e.err[kErrEdge] = 1'b1;
            return e;
        end
        for (int i = 0; i < DS; i++) begin
            self_i = (d[i].x == pos.x && d[i].y == pos.y);
            if (v[i] && !self_i) begin
                dx = int'(d[i].x);
                dy = int'(d[i].y);
                if (x_first) begin
                    if (dx < nx)      port = kPortWest;
                    else if (dx > nx) port = kPortEast;
                    else if (dy < ny) port = kPortNorth;
                    else if (dy > ny) port = kPortSouth;
                    else              port = kPortLocal;
                end else begin
                    if (dy < ny)      port = kPortNorth;
                    else if (dy > ny) port = kPortSouth;
                    else if (dx < nx) port = kPortWest;
                    else if (dx > nx) port = kPortEast;
                    else              port = kPortLocal;
                end
                e.mask[port][i] = 1'b1;
                e.nr[port]      = 1'b1;
            end
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin : pos_model
        if (rst) begin
            pos_q_m  <= '0;
            m_pos_ok <= 1'b0;
        end else begin
            pos_q_m  <= position;
            m_pos_ok <= 1'b1;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t ea;
        exp_t eb;
        logic exp_rdy;
        logic fire_m;
        ea = '0;
        eb = '0;
        if (rst) begin
            q_a.delete();
            q_b.delete();
            m_valid    = 1'b0;
            exp_status = '0;
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_routing", out_next_routing, 0);
            check("rst_mask", out_port_mask, 0);
            check("rst_err", out_err, 0);
            check("rst_err_status", err_status, 0);
        end else begin
            exp_rdy = m_pos_ok && (!m_valid || out_ready);
            check("in_ready_a", in_ready, exp_rdy);
            check("in_ready_b", in_ready_b, exp_rdy);
            check("out_valid_a", out_valid, m_valid);
            check("out_valid_b", out_valid_b, m_valid);
            check("err_status_a", err_status, exp_status);
            check("err_status_b", err_status_b, exp_status);
            if (m_valid) begin
                check("sb_depth", q_a.size(), 1);
                if (q_a.size() > 0 && q_b.size() > 0) begin
                    ea = q_a[0];
                    eb = q_b[0];
                    check("routing_a", out_next_routing, ea.nr);
                    check("mask_a", out_port_mask, ea.mask);
                    check("err_a", out_err, ea.err);
                    check("routing_b", out_next_routing_b, eb.nr);
                    check("mask_b", out_port_mask_b, eb.mask);
                    check("err_b", out_err_b, eb.err);
                    if (out_ready) begin
                        ea = q_a.pop_front();
                        eb = q_b.pop_front();
                    end
                end
            end
            if (clear_err)                  exp_status = '0;
            else if (m_valid && out_ready)  exp_status = exp_status | ea.err;
            fire_m = in_valid && exp_rdy;
            if (fire_m) begin
                q_a.push_back(model(pos_q_m, in_current_routing, in_destination, in_val, 1'b1));
                q_b.push_back(model(pos_q_m, in_current_routing, in_destination, in_val, 1'b0));
            end
            m_valid = fire_m ? 1'b1 : (out_ready ? 1'b0 : m_valid);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hdr(input direction_t cur, input logic [DS-1:0] v, input xy_t d0, input xy_t d1);
        in_current_routing = cur;
        in_val             = v;
        for (int i = 0; i < DS; i++) in_destination[i] = xy(7, 7);
        in_destination[0] = d0;
        in_destination[1] = d1;
    endtask

    // Holds in_valid until accepted (bounded); reports stalled cycles.
    task automatic send(output int waited);
        logic accepted;
        accepted = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            if (!accepted) waited++;
        end
        check("accept", accepted, 1);
    endtask

    task automatic rand_hdr();
        for (int i = 0; i < DS; i++) in_destination[i] = xy($urandom_range(0, 7), $urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) in_destination[$urandom_range(0, DS - 1)] = position;
        in_val = DS'($urandom);
        if ($urandom_range(0, 7) == 0) in_current_routing = direction_t'($urandom_range(0, 31));
        else                           in_current_routing = direction_t'(1 << $urandom_range(0, 4));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int w;
        position           = xy(3, 3);
        in_valid           = 1'b0;
        in_val             = '0;
        in_current_routing = '0;
        out_ready          = 1'b1;
        clear_err          = 1'b0;
        for (int i = 0; i < DS; i++) in_destination[i] = xy(0, 0);

        // 1: reset and the dead cycle afterwards.
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("dead_cycle_ready", in_ready, 0);
        @(negedge clk);
        check("ready_after_dead", in_ready, 1);
        check("idle_valid", out_valid, 0);
        step(1);

        // 2: basic multicast from (3,3) heading East, next hop (4,3).
        set_hdr(go_east, 6'b000011, xy(6, 3), xy(4, 1));
        send(w);
        in_valid = 1'b0;
        check("t2_latency", out_valid, 1);
        check("t2_routing", out_next_routing, go_east | go_north);
        check("t2_mask_east", out_port_mask[kPortEast], 6'b000001);
        check("t2_mask_north", out_port_mask[kPortNorth], 6'b000010);
        step(1);

        // 3: edge error, sticky status, clear, and clear beating a set.
        position = xy(0, 2);
        step(2);
        set_hdr(go_west, 6'b000001, xy(5, 5), xy(5, 5));
        send(w);
        in_valid = 1'b0;
        check("t3_err", out_err, 3'b100);
        check("t3_routing", out_next_routing, 0);
        step(1);
        check("t3_sticky", err_status[kErrEdge], 1);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        check("t3_cleared", err_status, 0);
        send(w);
        in_valid  = 1'b0;
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        check("t3_clear_wins", err_status, 0);
        position = xy(3, 3);
        step(2);

        // 4: one-hot error, masked-off request, local hop, self destination.
        set_hdr(5'b00110, 6'b000001, xy(5, 5), xy(5, 5));
        send(w);
        check("t4_onehot_err", out_err, 3'b001);
        check("t4_onehot_mask", out_port_mask, 0);
        set_hdr(5'b00110, 6'b000000, xy(5, 5), xy(5, 5));
        send(w);
        check("t4_noval_err", out_err, 0);
        set_hdr(go_local, 6'b000011, xy(5, 5), xy(1, 1));
        send(w);
        check("t4_local_routing", out_next_routing, 0);
        set_hdr(go_east, 6'b000011, xy(3, 3), xy(5, 3));
        send(w);
        in_valid = 1'b0;
        check("t4_self_err", out_err, 3'b010);
        check("t4_self_mask", out_port_mask[kPortEast], 6'b000010);
        step(1);

        // 5: backpressure, then same-cycle accept and back-to-back headers.
        out_ready = 1'b0;
        set_hdr(go_south, 6'b000011, xy(3, 7), xy(1, 4));
        send(w);
        in_valid = 1'b0;
        repeat (3) begin
            step(1);
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_ready", in_ready, 0);
        end
        set_hdr(go_north, 6'b000001, xy(3, 0), xy(0, 0));
        out_ready = 1'b1;
        send(w);
        check("t5_same_cycle", w, 0);
        for (int n = 0; n < 4; n++) begin
            rand_hdr();
            send(w);
            check("t5_back_to_back", w, 0);
        end
        in_valid = 1'b0;
        step(1);

        // Random headers with occasional backpressure.
        for (int n = 0; n < 24; n++) begin
            if (n % 4 == 0) position = xy($urandom_range(0, 7), $urandom_range(0, 7));
            rand_hdr();
            send(w);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                step($urandom_range(1, 2));
                out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
        step(2);

        // 6: X-first versus Y-first from (2,5) heading North, next hop (2,4).
        position = xy(2, 5);
        step(2);
        set_hdr(go_north, 6'b000001, xy(4, 1), xy(0, 0));
        send(w);
        in_valid = 1'b0;
        check("t6_x_first", out_next_routing, go_east);
        check("t6_y_first", out_next_routing_b, go_north);
        step(1);

        // Reset while a result is held.
        out_ready = 1'b0;
        set_hdr(go_west, 6'b000011, xy(0, 5), xy(2, 0));
        send(w);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_mask", out_port_mask, 0);
        step(1);
        rst       = 1'b0;
        out_ready = 1'b1;
        step(3);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
